// File: rtl/fetch_decode_unit.sv
// RV32I fetch/decode stage: fetches one word at a time from a wait-stated
// instruction memory, decodes it into registered fields, and hands it to
// execute over a valid/ready handshake. Supports PC redirect, optional RV32E
// register checking, and a sticky halt on SYSTEM.
module fetch_decode_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter bit          RV32E          = 1'b0,
    parameter bit          HALT_ON_SYSTEM = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [31:0] imem_addr,
    output logic        imem_rstrb,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rbusy,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    output logic [9:0]  d_opclass,
    output logic [4:0]  d_rd,
    output logic [4:0]  d_rs1,
    output logic [4:0]  d_rs2,
    output logic [2:0]  d_funct3,
    output logic [6:0]  d_funct7,
    output logic [31:0] d_imm,
    output logic        d_illegal,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_OUT,
        S_HALT
    } state_t;

    localparam int unsigned OC_ALUREG = 0;
    localparam int unsigned OC_ALUIMM = 1;
    localparam int unsigned OC_BRANCH = 2;
    localparam int unsigned OC_JALR   = 3;
    localparam int unsigned OC_JAL    = 4;
    localparam int unsigned OC_AUIPC  = 5;
    localparam int unsigned OC_LUI    = 6;
    localparam int unsigned OC_LOAD   = 7;
    localparam int unsigned OC_STORE  = 8;
    localparam int unsigned OC_SYSTEM = 9;

    state_t      state;
    logic [31:0] pc;
    logic        kill;

    logic [9:0]  dec_opclass;
    logic [31:0] dec_imm;
    logic        dec_illegal;
    logic [31:0] redir_target;

    assign redir_target = {redir_pc[31:2], 2'b00};

    // Fetch request is combinational so a redirect can veto it in the same cycle.
    always_comb begin
        imem_addr  = {pc[31:2], 2'b00};
        imem_rstrb = (state == S_REQ) && resetn && !redir_valid;
    end

    // Decode the incoming memory word; the result is only captured on a live return.
    always_comb begin
        logic [31:0] i;
        logic        uses_rd;
        logic        uses_rs1;
        logic        uses_rs2;
        i           = imem_rdata;
        dec_opclass = '0;
        dec_imm     = '0;
        dec_illegal = 1'b0;
        uses_rd     = 1'b0;
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;

        case (i[6:0])
            7'b0110011: dec_opclass[OC_ALUREG] = 1'b1;
            7'b0010011: dec_opclass[OC_ALUIMM] = 1'b1;
            7'b1100011: dec_opclass[OC_BRANCH] = 1'b1;
            7'b1100111: dec_opclass[OC_JALR]   = 1'b1;
            7'b1101111: dec_opclass[OC_JAL]    = 1'b1;
            7'b0010111: dec_opclass[OC_AUIPC]  = 1'b1;
            7'b0110111: dec_opclass[OC_LUI]    = 1'b1;
            7'b0000011: dec_opclass[OC_LOAD]   = 1'b1;
            7'b0100011: dec_opclass[OC_STORE]  = 1'b1;
            7'b1110011: dec_opclass[OC_SYSTEM] = 1'b1;
            default:    dec_opclass            = '0;
        endcase

        if (dec_opclass[OC_ALUIMM] || dec_opclass[OC_JALR] ||
            dec_opclass[OC_LOAD] || dec_opclass[OC_SYSTEM]) begin
            dec_imm = {{21{i[31]}}, i[30:20]};
        end else if (dec_opclass[OC_STORE]) begin
            dec_imm = {{21{i[31]}}, i[30:25], i[11:7]};
        end else if (dec_opclass[OC_BRANCH]) begin
            dec_imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        end else if (dec_opclass[OC_AUIPC] || dec_opclass[OC_LUI]) begin
            dec_imm = {i[31:12], 12'b0};
        end else if (dec_opclass[OC_JAL]) begin
            dec_imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        end

        uses_rd  = !(dec_opclass[OC_BRANCH] || dec_opclass[OC_STORE]);
        uses_rs1 = !(dec_opclass[OC_JAL] || dec_opclass[OC_AUIPC] || dec_opclass[OC_LUI]);
        uses_rs2 = dec_opclass[OC_ALUREG] || dec_opclass[OC_BRANCH] || dec_opclass[OC_STORE];

        dec_illegal = (dec_opclass == '0);
        if (RV32E && (dec_opclass != '0)) begin
            if ((uses_rd && i[11]) || (uses_rs1 && i[19]) || (uses_rs2 && i[24])) begin
                dec_illegal = 1'b1;
            end
        end
    end

    // Fetch/present state machine with redirect taking priority over the handshake.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_REQ;
            pc        <= RESET_PC & ~32'd3;
            kill      <= 1'b0;
            d_valid   <= 1'b0;
            d_pc      <= '0;
            d_instr   <= '0;
            d_opclass <= '0;
            d_rd      <= '0;
            d_rs1     <= '0;
            d_rs2     <= '0;
            d_funct3  <= '0;
            d_funct7  <= '0;
            d_imm     <= '0;
            d_illegal <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redir_valid) begin
                        pc <= redir_target;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redir_valid) begin
                        pc   <= redir_target;
                        kill <= 1'b1;
                    end
                    // A return that overlaps a redirect, or follows one, belongs to the old path.
                    if (!imem_rbusy) begin
                        if (kill || redir_valid) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            d_valid   <= 1'b1;
                            d_pc      <= pc;
                            d_instr   <= imem_rdata;
                            d_opclass <= dec_opclass;
                            d_rd      <= imem_rdata[11:7];
                            d_rs1     <= imem_rdata[19:15];
                            d_rs2     <= imem_rdata[24:20];
                            d_funct3  <= imem_rdata[14:12];
                            d_funct7  <= imem_rdata[31:25];
                            d_imm     <= dec_imm;
                            d_illegal <= dec_illegal;
                            state     <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (redir_valid) begin
                        d_valid <= 1'b0;
                        pc      <= redir_target;
                        state   <= S_REQ;
                    end else if (d_ready) begin
                        d_valid <= 1'b0;
                        pc      <= pc + 32'd4;
                        if (HALT_ON_SYSTEM && d_opclass[OC_SYSTEM] && !d_illegal) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end
                S_HALT: begin
                    d_valid <= 1'b0;
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit: hand-timed sequences for latency,
// wait states, stall, redirect and halt, plus a decode vector table.
module tb_fetch_decode_unit;

    typedef struct {
        logic [31:0] instr;
        logic [9:0]  opclass;
        logic [31:0] imm;
        logic        illegal;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] imem_addr;
    logic        imem_rstrb;
    logic [31:0] imem_rdata;
    logic        imem_rbusy;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic [9:0]  d_opclass;
    logic [4:0]  d_rd;
    logic [4:0]  d_rs1;
    logic [4:0]  d_rs2;
    logic [2:0]  d_funct3;
    logic [6:0]  d_funct7;
    logic [31:0] d_imm;
    logic        d_illegal;
    logic        halted;

    // RV32E instance with a trivial always-ready memory.
    logic        resetn_e;
    logic [31:0] e_word;
    logic [31:0] e_addr;
    logic        e_rstrb;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [9:0]  e_opclass;
    logic [4:0]  e_rd;
    logic [4:0]  e_rs1;
    logic [4:0]  e_rs2;
    logic [2:0]  e_funct3;
    logic [6:0]  e_funct7;
    logic [31:0] e_imm;
    logic        e_illegal;
    logic        e_halted;

    logic [31:0] mem [0:255];
    logic [31:0] lat_addr = '0;
    int unsigned cnt = 0;
    int unsigned wait_n = 0;
    int unsigned strobe_cnt = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    vec_t        vecs [13];

    always #5 clk = ~clk;

    fetch_decode_unit dut (
        .clk(clk), .resetn(resetn),
        .imem_addr(imem_addr), .imem_rstrb(imem_rstrb),
        .imem_rdata(imem_rdata), .imem_rbusy(imem_rbusy),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .d_valid(d_valid), .d_ready(d_ready), .d_pc(d_pc), .d_instr(d_instr),
        .d_opclass(d_opclass), .d_rd(d_rd), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_funct3(d_funct3), .d_funct7(d_funct7), .d_imm(d_imm),
        .d_illegal(d_illegal), .halted(halted)
    );

    fetch_decode_unit #(.RV32E(1'b1)) dut_e (
        .clk(clk), .resetn(resetn_e),
        .imem_addr(e_addr), .imem_rstrb(e_rstrb),
        .imem_rdata(e_word), .imem_rbusy(1'b0),
        .redir_valid(1'b0), .redir_pc(32'h0),
        .d_valid(e_valid), .d_ready(1'b0), .d_pc(e_pc), .d_instr(e_instr),
        .d_opclass(e_opclass), .d_rd(e_rd), .d_rs1(e_rs1), .d_rs2(e_rs2),
        .d_funct3(e_funct3), .d_funct7(e_funct7), .d_imm(e_imm),
        .d_illegal(e_illegal), .halted(e_halted)
    );

    // Memory model: latch address on strobe, stay busy for wait_n cycles.
    always @(posedge clk) begin
        if (imem_rstrb) begin
            lat_addr   <= imem_addr;
            cnt        <= wait_n;
            strobe_cnt <= strobe_cnt + 1;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
        end
    end

    assign imem_rbusy = (cnt != 0);
    assign imem_rdata = (cnt != 0) ? 32'hDEADBEEF : mem[lat_addr[9:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (d_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, {31'b0, d_valid}, 32'd1);
    endtask

    task automatic run_e(input string name, input logic [31:0] w, input logic exp_ill);
        resetn_e = 1'b0;
        e_word   = w;
        repeat (2) @(negedge clk);
        resetn_e = 1'b1;
        repeat (2) @(negedge clk);
        chk({name, "_valid"}, {31'b0, e_valid}, 32'd1);
        chk({name, "_illegal"}, {31'b0, e_illegal}, {31'b0, exp_ill});
    endtask

    initial begin
        int unsigned sc;

        for (int i = 0; i < 256; i++) mem[i] = 32'h00000013;
        mem[0]    = 32'h00100093;
        mem[1]    = 32'h00200113;
        mem[2]    = 32'h00300193;
        mem[8'h40] = 32'h123452B7;

        vecs[0]  = '{32'hFE20AE23, 10'h100, 32'hFFFFFFFC, 1'b0};
        vecs[1]  = '{32'hFE000EE3, 10'h004, 32'hFFFFFFFC, 1'b0};
        vecs[2]  = '{32'h0080006F, 10'h010, 32'h00000008, 1'b0};
        vecs[3]  = '{32'h123452B7, 10'h040, 32'h12345000, 1'b0};
        vecs[4]  = '{32'h0000007F, 10'h000, 32'h00000000, 1'b1};
        vecs[5]  = '{32'h002081B3, 10'h001, 32'h00000000, 1'b0};
        vecs[6]  = '{32'h00000833, 10'h001, 32'h00000000, 1'b0};
        vecs[7]  = '{32'h0040A183, 10'h080, 32'h00000004, 1'b0};
        vecs[8]  = '{32'h00008067, 10'h008, 32'h00000000, 1'b0};
        vecs[9]  = '{32'h00001297, 10'h020, 32'h00001000, 1'b0};
        vecs[10] = '{32'hFFF00093, 10'h002, 32'hFFFFFFFF, 1'b0};
        vecs[11] = '{32'h00100091, 10'h000, 32'h00000000, 1'b1};
        vecs[12] = '{32'h00100073, 10'h200, 32'h00000001, 1'b0};
        for (int k = 0; k < 13; k++) mem[128 + k] = vecs[k].instr;

        resetn      = 1'b0;
        resetn_e    = 1'b0;
        e_word      = 32'h00000013;
        d_ready     = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_valid", {31'b0, d_valid}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_rstrb", {31'b0, imem_rstrb}, 32'd0);
        chk("rst_instr", d_instr, 32'd0);
        chk("rst_opclass", {22'b0, d_opclass}, 32'd0);
        chk("rst_imm", d_imm, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);

        // Zero-wait first fetch: strobe in cycle 0, d_valid visible in cycle 2
        resetn = 1'b1;
        #1;
        chk("c0_rstrb", {31'b0, imem_rstrb}, 32'd1);
        chk("c0_addr", imem_addr, 32'd0);
        @(negedge clk);
        chk("c1_valid", {31'b0, d_valid}, 32'd0);
        @(negedge clk);
        chk("c2_valid", {31'b0, d_valid}, 32'd1);
        chk("c2_opclass", {22'b0, d_opclass}, 32'h002);
        chk("c2_rd", {27'b0, d_rd}, 32'd1);
        chk("c2_rs1", {27'b0, d_rs1}, 32'd0);
        chk("c2_imm", d_imm, 32'd1);
        chk("c2_pc", d_pc, 32'd0);
        chk("c2_instr", d_instr, 32'h00100093);
        d_ready = 1'b1;
        wait_n  = 3;
        @(negedge clk);
        d_ready = 1'b0;
        #1;
        chk("next_rstrb", {31'b0, imem_rstrb}, 32'd1);
        chk("next_addr", imem_addr, 32'd4);

        // Three busy cycles delay d_valid by three cycles
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("busy_valid_low", {31'b0, d_valid}, 32'd0);
        end
        @(negedge clk);
        chk("busy_valid", {31'b0, d_valid}, 32'd1);
        chk("busy_instr", d_instr, 32'h00200113);

        // Stall in OUT for 5 cycles
        sc = strobe_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'b0, d_valid}, 32'd1);
            chk("stall_instr", d_instr, 32'h00200113);
            chk("stall_pc", d_pc, 32'd4);
            chk("stall_nostrobe", strobe_cnt, sc);
        end
        d_ready = 1'b1;
        wait_n  = 2;
        @(negedge clk);
        d_ready = 1'b0;
        #1;
        chk("adv_addr", imem_addr, 32'd8);
        chk("adv_rstrb", {31'b0, imem_rstrb}, 32'd1);

        // Redirect to 0x103 while waiting on the fetch of 0x8
        @(negedge clk);
        redir_valid = 1'b1;
        redir_pc    = 32'h103;
        @(negedge clk);
        redir_valid = 1'b0;
        chk("kill_valid_a", {31'b0, d_valid}, 32'd0);
        @(negedge clk);
        chk("kill_valid_b", {31'b0, d_valid}, 32'd0);
        chk("kill_rstrb_b", {31'b0, imem_rstrb}, 32'd0);
        wait_n = 0;
        @(negedge clk);
        #1;
        chk("kill_valid_c", {31'b0, d_valid}, 32'd0);
        chk("redir_rstrb", {31'b0, imem_rstrb}, 32'd1);
        chk("redir_addr", imem_addr, 32'h100);
        wait_valid("redir_fetch");
        chk("redir_pc", d_pc, 32'h100);
        chk("redir_instr", d_instr, 32'h123452B7);

        // Redirect coincident with d_ready drops the presented instruction
        d_ready     = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = 32'h200;
        @(negedge clk);
        d_ready     = 1'b0;
        redir_valid = 1'b0;
        #1;
        chk("drop_valid", {31'b0, d_valid}, 32'd0);
        chk("drop_rstrb", {31'b0, imem_rstrb}, 32'd1);
        chk("drop_addr", imem_addr, 32'h200);

        // Decode vector table, fetched sequentially from 0x200
        for (int k = 0; k < 13; k++) begin
            wait_valid("vec");
            chk($sformatf("vec%0d_pc", k), d_pc, 32'h200 + 32'(k * 4));
            chk($sformatf("vec%0d_instr", k), d_instr, vecs[k].instr);
            chk($sformatf("vec%0d_opclass", k), {22'b0, d_opclass}, {22'b0, vecs[k].opclass});
            chk($sformatf("vec%0d_imm", k), d_imm, vecs[k].imm);
            chk($sformatf("vec%0d_illegal", k), {31'b0, d_illegal}, {31'b0, vecs[k].illegal});
            d_ready = 1'b1;
            @(negedge clk);
            d_ready = 1'b0;
        end

        // After ebreak handshake: halted, no strobes, redirects ignored
        chk("halt_flag", {31'b0, halted}, 32'd1);
        chk("halt_valid", {31'b0, d_valid}, 32'd0);
        chk("halt_rstrb", {31'b0, imem_rstrb}, 32'd0);
        sc = strobe_cnt;
        redir_valid = 1'b1;
        redir_pc    = 32'h0;
        d_ready     = 1'b1;
        repeat (8) @(negedge clk);
        redir_valid = 1'b0;
        d_ready     = 1'b0;
        repeat (2) @(negedge clk);
        chk("halt_nostrobe", strobe_cnt, sc);
        chk("halt_sticky", {31'b0, halted}, 32'd1);
        chk("halt_valid2", {31'b0, d_valid}, 32'd0);

        // Reset clears halt; reset in WAIT abandons the fetch
        resetn = 1'b0;
        @(negedge clk);
        chk("rst2_halted", {31'b0, halted}, 32'd0);
        wait_n = 3;
        resetn = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("midwait_valid", {31'b0, d_valid}, 32'd0);
        wait_n = 0;
        resetn = 1'b1;
        @(negedge clk);
        chk("midwait_valid_b", {31'b0, d_valid}, 32'd0);
        @(negedge clk);
        chk("midwait_valid_c", {31'b0, d_valid}, 32'd1);
        chk("midwait_pc", d_pc, 32'd0);
        chk("midwait_instr", d_instr, 32'h00100093);

        // RV32E register range checks
        run_e("e_add_x16", 32'h00000833, 1'b1);
        run_e("e_add_x15", 32'h00D707B3, 1'b0);
        run_e("e_beq_rdfield", 32'h00000863, 1'b0);
        run_e("e_sw_rs2_16", 32'h01002023, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
